// File: rtl/edm_pulse_gen_pkg.sv
// ============================================================================
// Module  : edm_pulse_gen_pkg
// Brief   : Shared state encodings, waveform codes and helpers for EDM pulsing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package edm_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ON   = 2'b10,
    ST_OFF  = 2'b11
  } edm_state_t;

  localparam logic [1:0] c_WF_RECT = 2'b00;
  localparam logic [1:0] c_WF_SOFT = 2'b01;

  // Raises a Ton/Toff request to the configured minimum length.
  function automatic logic [15:0] clamp_units(input logic [15:0] data,
                                              input logic [15:0] min_t);
    return (data < min_t) ? min_t : data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edm_pulse_gen_tick_timer.sv
// ============================================================================
// Module  : edm_pulse_gen_tick_timer
// Brief   : TICK_DIV prescaler plus 16-bit unit down-counter; done on last tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edm_pulse_gen_tick_timer #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] len,
  output logic        done,
  output logic        unit_end,
  output logic        first_unit
);

  localparam int unsigned          c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

  logic [c_TICK_W-1:0] r_tick;
  logic [15:0]         r_units;
  logic                r_first;

  // A load restarts the prescaler so every phase begins on a fresh unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick  <= '0;
      r_units <= '0;
      r_first <= 1'b0;
    end else if (load) begin
      r_tick  <= '0;
      r_units <= len - 16'd1;
      r_first <= 1'b1;
    end else if (en) begin
      if (unit_end) begin
        r_tick  <= '0;
        r_units <= r_units - 16'd1;
        r_first <= 1'b0;
      end else begin
        r_tick  <= r_tick + c_TICK_W'(1);
      end
    end
  end

  assign unit_end   = en && (r_tick == c_TICK_LAST);
  assign done       = unit_end && (r_units == 16'd0);
  assign first_unit = r_first;

endmodule

`default_nettype wire

// File: rtl/edm_pulse_gen.sv
// ============================================================================
// Module  : edm_pulse_gen
// Brief   : EDM discharge pulse timing generator (IDLE/LOAD/ON/OFF) with
//           shadowed Ton/Toff/Ip/waveform. Optional macro EDM_PULSE_CNT_EN
//           turns feedback_data into a count of completed ON phases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edm_pulse_gen
  import edm_pulse_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned MIN_T    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        machine_start,
  input  logic        machine_stop,
  input  logic [15:0] Ton_data,
  input  logic [15:0] Toff_data,
  input  logic [15:0] Ip_data,
  input  logic [15:0] waveform_data,
  output logic        pulse_out,
  output logic [15:0] ip_ref,
  output logic        running,
  output logic [15:0] feedback_data
);

  localparam logic [15:0] c_MIN_T = 16'(MIN_T);

  edm_state_t  r_state;
  edm_state_t  w_next_state;
  logic [15:0] r_ton_sh;
  logic [15:0] r_toff_sh;
  logic [15:0] r_ip_sh;
  logic [1:0]  r_wf_sh;
  logic        w_start_ok;
  logic        w_done;
  logic        w_unit_end;
  logic        w_first_unit;
  logic        w_tmr_en;
  logic        w_tmr_load;
  logic [15:0] w_tmr_len;
  logic        w_soft_win;
  logic [15:0] w_ip_next;
  logic        w_unused;

  assign w_unused   = ^waveform_data[15:2];
  assign w_start_ok = (r_state == ST_IDLE) && machine_start && !machine_stop;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_ON;
      ST_ON:   if (w_done) w_next_state = ST_OFF;
      ST_OFF:  if (w_done) w_next_state = ST_LOAD;
      default: w_next_state = ST_IDLE;
    endcase
    if (machine_stop) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Shadows update on the edge into LOAD, so they are stable for the LOAD cycle and the whole period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ton_sh  <= '0;
      r_toff_sh <= '0;
      r_ip_sh   <= '0;
      r_wf_sh   <= '0;
    end else if (w_next_state == ST_LOAD) begin
      r_ton_sh  <= clamp_units(Ton_data, c_MIN_T);
      r_toff_sh <= clamp_units(Toff_data, c_MIN_T);
      r_ip_sh   <= Ip_data;
      r_wf_sh   <= waveform_data[1:0];
    end
  end

  assign w_tmr_en   = (r_state == ST_ON) || (r_state == ST_OFF);
  assign w_tmr_load = (r_state == ST_LOAD) || ((r_state == ST_ON) && w_done);
  assign w_tmr_len  = (r_state == ST_LOAD) ? r_ton_sh : r_toff_sh;

  edm_pulse_gen_tick_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_tmr_en),
    .load       (w_tmr_load),
    .len        (w_tmr_len),
    .done       (w_done),
    .unit_end   (w_unit_end),
    .first_unit (w_first_unit)
  );

  // Soft-start window covers the first TICK_DIV cycles of ON, looked at one cycle ahead.
  assign w_soft_win = (r_state == ST_LOAD) || (w_first_unit && !w_unit_end);

  always_comb begin
    w_ip_next = '0;
    if (w_next_state == ST_ON) begin
      case (r_wf_sh)
        c_WF_RECT: w_ip_next = r_ip_sh;
        c_WF_SOFT: w_ip_next = w_soft_win ? (r_ip_sh >> 1) : r_ip_sh;
        default:   w_ip_next = r_ip_sh;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_out <= 1'b0;
      ip_ref    <= '0;
      running   <= 1'b0;
    end else begin
      pulse_out <= (w_next_state == ST_ON);
      ip_ref    <= w_ip_next;
      running   <= (w_next_state != ST_IDLE);
    end
  end

`ifdef EDM_PULSE_CNT_EN
  logic [15:0] r_on_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_on_count <= '0;
    else if (w_start_ok)
      r_on_count <= '0;
    else if ((r_state == ST_ON) && (w_next_state == ST_OFF))
      r_on_count <= r_on_count + 16'd1;
  end

  assign feedback_data = r_on_count;
`else
  logic [15:0] r_feedback;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_feedback <= '0;
    else
      r_feedback <= {13'd0, (w_next_state == ST_OFF), (w_next_state != ST_IDLE),
                     (w_next_state == ST_ON)};
  end

  assign feedback_data = r_feedback;
`endif

endmodule

`default_nettype wire

// File: tb/tb_edm_pulse_gen.sv
// ============================================================================
// Module  : tb_edm_pulse_gen
// Brief   : Directed self-checking bench for edm_pulse_gen (TICK_DIV=10, MIN_T=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edm_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        machine_start = 1'b0;
  logic        machine_stop = 1'b0;
  logic [15:0] Ton_data = '0;
  logic [15:0] Toff_data = '0;
  logic [15:0] Ip_data = '0;
  logic [15:0] waveform_data = '0;
  logic        pulse_out;
  logic [15:0] ip_ref;
  logic        running;
  logic [15:0] feedback_data;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef EDM_PULSE_CNT_EN
  localparam logic [15:0] c_FB_ON  = 16'h0000;
  localparam logic [15:0] c_FB_OFF = 16'h0001;
`else
  localparam logic [15:0] c_FB_ON  = 16'h0003;
  localparam logic [15:0] c_FB_OFF = 16'h0006;
`endif

  edm_pulse_gen #(
    .TICK_DIV (10),
    .MIN_T    (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .machine_start (machine_start),
    .machine_stop  (machine_stop),
    .Ton_data      (Ton_data),
    .Toff_data     (Toff_data),
    .Ip_data       (Ip_data),
    .waveform_data (waveform_data),
    .pulse_out     (pulse_out),
    .ip_ref        (ip_ref),
    .running       (running),
    .feedback_data (feedback_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    machine_start = 1'b1;
    step();
    machine_start = 1'b0;
  endtask

  task automatic do_stop();
    machine_stop = 1'b1;
    step();
    machine_stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({pulse_out, running, ip_ref, feedback_data} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {pulse_out, running, ip_ref, feedback_data});
    end
    rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if ({pulse_out, running} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got %b expected 00", {pulse_out, running});
    end
  endtask

  task automatic test_rect();
    int hi, lo, bad;
    Ton_data = 16'd3; Toff_data = 16'd5; waveform_data = 16'h0000; Ip_data = 16'h0400;
    pulse_start();
    n_cmp++;
    if ({running, pulse_out, ip_ref} !== {1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL rect_load: got %h expected 20000", {running, pulse_out, ip_ref});
    end
    step();
    n_cmp++;
    if (feedback_data !== c_FB_ON) begin
      n_fail++;
      $display("FAIL rect_fb_on: got %h expected %h", feedback_data, c_FB_ON);
    end
    hi = 0; lo = 0; bad = 0;
    for (int i = 0; i < 200 && pulse_out === 1'b1; i++) begin
      if (ip_ref !== 16'h0400) bad++;
      hi++;
      step();
    end
    n_cmp++;
    if (feedback_data !== c_FB_OFF) begin
      n_fail++;
      $display("FAIL rect_fb_off: got %h expected %h", feedback_data, c_FB_OFF);
    end
    for (int i = 0; i < 200 && pulse_out === 1'b0; i++) begin
      if (ip_ref !== 16'h0000) bad++;
      lo++;
      step();
    end
    n_cmp++;
    if (hi !== 30) begin n_fail++; $display("FAIL rect_on_len: got %0d expected 30", hi); end
    n_cmp++;
    if (lo !== 51) begin n_fail++; $display("FAIL rect_off_len: got %0d expected 51", lo); end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL rect_ip_ref: got %0d bad cycles expected 0", bad); end
    do_stop();
  endtask

  task automatic test_soft();
    logic [15:0] exp;
    Ton_data = 16'd2; Toff_data = 16'd1; waveform_data = 16'hFFFD; Ip_data = 16'h0400;
    pulse_start();
    step();
    for (int i = 0; i < 20; i++) begin
      exp = (i < 10) ? 16'h0200 : 16'h0400;
      n_cmp++;
      if ({pulse_out, ip_ref} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL soft_ip_cycle%0d: got %h expected %h", i, {pulse_out, ip_ref}, {1'b1, exp});
      end
      step();
    end
    n_cmp++;
    if ({pulse_out, ip_ref} !== 17'd0) begin
      n_fail++;
      $display("FAIL soft_off: got %h expected 0", {pulse_out, ip_ref});
    end
    do_stop();
  endtask

  task automatic test_stop();
    Ton_data = 16'd3; Toff_data = 16'd5; waveform_data = 16'h0000; Ip_data = 16'h0400;
    pulse_start();
    step();
    repeat (7) step();
    n_cmp++;
    if (pulse_out !== 1'b1) begin n_fail++; $display("FAIL stop_pre_on: got %b expected 1", pulse_out); end
    do_stop();
    n_cmp++;
    if ({pulse_out, running, ip_ref, feedback_data} !== 34'd0) begin
      n_fail++;
      $display("FAIL stop_truncate: got %h expected 0", {pulse_out, running, ip_ref, feedback_data});
    end
    do_stop();
    n_cmp++;
    if ({pulse_out, running} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_twice: got %b expected 00", {pulse_out, running});
    end
    machine_start = 1'b1; machine_stop = 1'b1;
    step();
    machine_start = 1'b0; machine_stop = 1'b0;
    step();
    n_cmp++;
    if ({pulse_out, running} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_stop_same: got %b expected 00", {pulse_out, running});
    end
  endtask

  task automatic test_clamp();
    int hi, lo, hi2;
    Ton_data = 16'd0; Toff_data = 16'd0; waveform_data = 16'h0000; Ip_data = 16'h0123;
    pulse_start();
    step();
    hi = 0; lo = 0; hi2 = 0;
    for (int i = 0; i < 200 && pulse_out === 1'b1; i++) begin
      hi++;
      if (hi == 3) Ton_data = 16'd6;
      step();
    end
    for (int i = 0; i < 200 && pulse_out === 1'b0; i++) begin
      lo++;
      machine_start = (lo == 4);
      step();
    end
    machine_start = 1'b0;
    for (int i = 0; i < 200 && pulse_out === 1'b1; i++) begin
      hi2++;
      step();
    end
    n_cmp++;
    if (hi !== 10) begin n_fail++; $display("FAIL clamp_on_len: got %0d expected 10", hi); end
    n_cmp++;
    if (lo !== 11) begin n_fail++; $display("FAIL clamp_off_len: got %0d expected 11", lo); end
    n_cmp++;
    if (hi2 !== 60) begin n_fail++; $display("FAIL shadow_next_on: got %0d expected 60", hi2); end
    do_stop();
  endtask

`ifdef EDM_PULSE_CNT_EN
  task automatic test_count();
    int  falls;
    logic prev;
    Ton_data = 16'd1; Toff_data = 16'd1; waveform_data = 16'h0000; Ip_data = 16'h0010;
    pulse_start();
    n_cmp++;
    if (feedback_data !== 16'd0) begin n_fail++; $display("FAIL cnt_clear: got %h expected 0", feedback_data); end
    falls = 0;
    prev = pulse_out;
    for (int i = 0; i < 300 && falls < 4; i++) begin
      step();
      if (prev && !pulse_out) falls++;
      prev = pulse_out;
    end
    n_cmp++;
    if (feedback_data !== 16'd4) begin n_fail++; $display("FAIL cnt_four: got %h expected 0004", feedback_data); end
    do_stop();
    step();
    n_cmp++;
    if (feedback_data !== 16'd4) begin n_fail++; $display("FAIL cnt_hold: got %h expected 0004", feedback_data); end
    pulse_start();
    n_cmp++;
    if (feedback_data !== 16'd0) begin n_fail++; $display("FAIL cnt_restart: got %h expected 0", feedback_data); end
    do_stop();
  endtask
`else
  task automatic test_status();
    Ton_data = 16'd1; Toff_data = 16'd1; waveform_data = 16'h0000; Ip_data = 16'h0010;
    pulse_start();
    n_cmp++;
    if (feedback_data !== 16'h0002) begin n_fail++; $display("FAIL status_load: got %h expected 0002", feedback_data); end
    step();
    n_cmp++;
    if (feedback_data !== 16'h0003) begin n_fail++; $display("FAIL status_on: got %h expected 0003", feedback_data); end
    repeat (10) step();
    n_cmp++;
    if (feedback_data !== 16'h0006) begin n_fail++; $display("FAIL status_off: got %h expected 0006", feedback_data); end
    do_stop();
    n_cmp++;
    if (feedback_data !== 16'h0000) begin n_fail++; $display("FAIL status_idle: got %h expected 0000", feedback_data); end
  endtask
`endif

  task automatic test_reset_mid();
    Ton_data = 16'd3; Toff_data = 16'd5; waveform_data = 16'h0000; Ip_data = 16'h0400;
    pulse_start();
    step();
    for (int i = 0; i < 100 && pulse_out === 1'b1; i++) step();
    repeat (5) step();
    n_cmp++;
    if ({pulse_out, running} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_in_off: got %b expected 01", {pulse_out, running});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pulse_out, running, ip_ref, feedback_data} !== 34'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected 0", {pulse_out, running, ip_ref, feedback_data});
    end
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({pulse_out, running} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_stays_idle: got %b expected 00", {pulse_out, running});
    end
    pulse_start();
    step();
    n_cmp++;
    if ({pulse_out, running, ip_ref} !== {1'b1, 1'b1, 16'h0400}) begin
      n_fail++;
      $display("FAIL rstmid_restart: got %h expected 30400", {pulse_out, running, ip_ref});
    end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_rect();
    test_soft();
    test_stop();
    test_clamp();
`ifdef EDM_PULSE_CNT_EN
    test_count();
`else
    test_status();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
